// File: rtl/uart_rx_fifo.sv
// UART receive FWFT byte FIFO with sticky overrun flag.
// Define UART_RX_FIFO_DROP_OLDEST_EN to keep the newest byte on overrun.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] CNT_FULL =
    (ADDR_BITS+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   cnt;
  logic                 ovr;

  logic pop;
  logic push;
  logic ovr_ev;
  logic wr_en;
  logic rd_adv;

  assign out_valid = (cnt != '0);
  assign full      = (cnt == CNT_FULL);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt;
  assign overrun   = ovr;

  assign pop    = out_valid && out_ready;
  assign push   = in_valid && (!full || pop);
  assign ovr_ev = in_valid && full && !pop;

`ifdef UART_RX_FIFO_DROP_OLDEST_EN
  // Overrun evicts the head so the newest byte is kept.
  assign wr_en  = push || ovr_ev;
  assign rd_adv = pop || ovr_ev;
`else
  assign wr_en  = push;
  assign rd_adv = pop;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + (ADDR_BITS+1)'(1);
    end else if (pop && !push) begin
      cnt <= cnt - (ADDR_BITS+1)'(1);
    end
  end

  // A fresh overrun wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else if (ovr_ev) begin
      ovr <= 1'b1;
    end else if (overrun_clr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: vector table, directed corners,
// random traffic against a queue scoreboard.
module tb_uart_rx_fifo;

  localparam int DB    = 8;
  localparam int AB    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [DB-1:0] in_data;
  logic          in_valid;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AB:0]   count;
  logic          full;
  logic          overrun;
  logic          overrun_clr;

  uart_rx_fifo #(
    .DATA_BITS(DB),
    .ADDR_BITS(AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DB-1:0] q[$];
  logic          ovr_m;
  logic [DB-1:0] last_pop;

  typedef struct {
    logic          v;
    logic [DB-1:0] d;
    logic          r;
    logic          c;
    int            cnt;
    logic          ov;
    logic [DB-1:0] dat;
    logic          ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid),
        32'(q.size() != 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    if (q.size() != 0) begin
      chk("head", 32'(out_data), 32'(q[0]));
    end
  endtask

  task automatic cycle(input logic v,
                       input logic [DB-1:0] d,
                       input logic r,
                       input logic c);
    logic pop_m;
    logic full_m;
    logic ev;
    in_valid    = v;
    in_data     = d;
    out_ready   = r;
    overrun_clr = c;
    full_m = (q.size() == DEPTH);
    pop_m  = r && (q.size() != 0);
    ev     = v && full_m && !pop_m;
    if (pop_m) begin
      chk("pop_data", 32'(out_data), 32'(q[0]));
      last_pop = q.pop_front();
    end
    if (v && !ev) q.push_back(d);
`ifdef UART_RX_FIFO_DROP_OLDEST_EN
    if (ev) begin
      void'(q.pop_front());
      q.push_back(d);
    end
`endif
    if (ev) ovr_m = 1'b1;
    else if (c) ovr_m = 1'b0;
    @(posedge clk);
    #1;
    check_state();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    ovr_m       = 1'b0;
    last_pop    = '0;

    tbl[0] = '{1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0};
    tbl[1] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[2] = '{1, 8'h3C, 1, 0, 1, 1, 8'h3C, 0};
    tbl[3] = '{1, 8'hC3, 1, 0, 1, 1, 8'hC3, 0};
    tbl[4] = '{0, 8'h00, 0, 1, 1, 1, 8'hC3, 0};
    tbl[5] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_data", 32'(out_data), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ov));
      chk("tbl_ovr", 32'(overrun), 32'(tbl[i].ovr));
      if (tbl[i].ov) begin
        chk("tbl_data", 32'(out_data), 32'(tbl[i].dat));
      end
    end

    for (int i = 0; i < DEPTH; i++) cycle(1, DB'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_ovr", 32'(overrun), 0);

    cycle(1, 8'h55, 0, 0);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_count", 32'(count), 16);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
`ifdef UART_RX_FIFO_DROP_OLDEST_EN
    chk("ovr_last", 32'(last_pop), 32'h55);
`else
    chk("ovr_last", 32'(last_pop), 32'h0F);
`endif
    chk("drain_count", 32'(count), 0);

    for (int i = 0; i < DEPTH; i++) cycle(1, DB'(i), 0, 0);
    cycle(1, 8'h66, 0, 0);
    cycle(1, 8'h99, 0, 1);
    chk("clr_vs_set", 32'(overrun), 1);
    cycle(0, 8'h00, 0, 1);
    chk("clr_alone", 32'(overrun), 0);

    cycle(1, 8'h77, 1, 0);
    chk("pp_ovr", 32'(overrun), 0);
    chk("pp_count", 32'(count), 16);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);
    chk("pp_last", 32'(last_pop), 32'h77);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 55,
            DB'($urandom),
            $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 5);
    end

    while (q.size() != 0) cycle(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, DB'(8'h40 + i), 0, 0);
    chk("pre_rst_count", 32'(count), 5);
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    ovr_m = 1'b0;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_full", 32'(full), 0);
    chk("arst_ovr", 32'(overrun), 0);
    chk("arst_data", 32'(out_data), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 8'h3A, 0, 0);
    chk("post_count", 32'(count), 1);
    chk("post_data", 32'(out_data), 32'h3A);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
